quaddemux: RTL and testbench
============================

QUADDEMUX -- requirements
Module: quaddemux

Interface
REQ-001 Parameter WIDTH, default 1: data width of every lane in bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous assert, active low.
REQ-005 in_valid  input  1  write request present.
REQ-006 in_ready  output  1  request accepted this cycle when high together with in_valid.
REQ-007 in_data  input  WIDTH  write payload.
REQ-008 s  input  2  destination lane: 0=a, 1=b, 2=c, 3=d; same encoding as the quadmux select.
REQ-009 bcast  input  1  write in_data to all four lanes; s is ignored.
REQ-010 a, b, c, d  output  WIDTH each  lane data registers.
REQ-011 a_valid, b_valid, c_valid, d_valid  output  1 each  lane holds unconsumed data.
REQ-012 a_ready, b_ready, c_ready, d_ready  input  1 each  consumer takes the lane word when its valid is also high.

Function
REQ-013 Each lane SHALL be a one-deep buffer: data register plus valid flag.
REQ-014 A lane is "free" this cycle when its valid is low, or when valid and ready are both high (drain and refill in the same cycle).
REQ-015 Unicast: in_ready SHALL be high exactly when the lane selected by s is free; the other lanes' state does not affect it.
REQ-016 Broadcast: in_ready SHALL be high exactly when all four lanes are free.
REQ-017 in_ready SHALL be combinational from s, bcast, the lane valids and the lane readies; it SHALL NOT depend on in_valid.
REQ-018 On accept, the data SHALL appear on the target lane output(s), with valid high, on the next rising edge. Latency is 1 cycle; there is no combinational in-to-out path.
REQ-019 On a lane with valid and ready high and no new write, valid SHALL clear at the next edge. The data register holds its last value.
REQ-020 When the same lane drains and is written in one cycle, the new word SHALL replace the old one, valid stays high, and no bubble occurs.
REQ-021 Lane data SHALL be held stable while valid is high and ready is low.
REQ-022 A request that is not accepted (in_valid high, in_ready low) SHALL cause no state change. The requester must hold in_data, s and bcast stable until accepted.
REQ-023 Lanes not targeted SHALL drain independently every cycle.
REQ-024 Sustained throughput SHALL be one accepted word per cycle, provided the targeted consumer keeps ready high.

Reset
REQ-025 While rst_n is low, all four valids SHALL be 0 and a, b, c, d SHALL be 0, immediately and without waiting for a clock edge.
REQ-026 in_ready during reset follows REQ-015/016 with all lanes empty, so it reads 1. Writes attempted while rst_n is low SHALL be discarded.
REQ-027 Reset in mid-transfer SHALL discard all buffered words. The first edge after deassertion behaves as if every lane is empty.

Structure
REQ-028 The lane encoding constants (LANE_A..LANE_D = 2'd0..2'd3) SHALL live in the shared package/header used by quadmux.
REQ-029 One sub-module, quaddemux_lane, SHALL implement the one-deep buffer (ports: clk, rst_n, wr, wdata, ready, q, valid, free). quaddemux instantiates it four times and adds the select, broadcast and in_ready logic.

Verification
REQ-030 Reset then idle: rst_n=0 with WIDTH=8 -> all valids 0, all outputs 0, in_ready=1; after release, state unchanged until the first accept.
REQ-031 Unicast fill/stall: s=2, in_data=8'h5A, c_ready=0; accept -> next cycle c=8'h5A, c_valid=1. Second write to s=2 -> in_ready=0 and c stays 8'h5A. A write to s=0 with 8'h11 -> accepted, a=8'h11.
REQ-032 Drain+refill: c_valid=1, c_ready=1, write s=2 with 8'hA5 -> in_ready=1 and next cycle c=8'hA5, c_valid=1, with no bubble. Back-to-back words 1,2,3 to lane 1 with b_ready=1 -> b sequence 1,2,3 on consecutive cycles.
REQ-033 Broadcast: all lanes empty, bcast=1, in_data=8'h3C -> all four outputs 8'h3C, all valids 1. With d_valid=1 and d_ready=0, broadcast gets in_ready=0 and no lane changes.
REQ-034 Reset mid-operation: lanes a and d full, assert rst_n asynchronously between edges -> valids drop before the next edge; after release, a write to s=3 is accepted in the first cycle.
REQ-035 Randomized round-trip with WIDTH=1: drive quaddemux outputs through quadmux with the same s, random ready/valid over 6 input bits -> every accepted word is read back unchanged and no word is lost or duplicated.

Source files
------------

// File: rtl/quaddemux_pkg.sv
// Shared lane encoding for the quad mux/demux pair, plus the select decoder.
// The same constants give the lane order used by quadmux.
package quaddemux_pkg;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;
  localparam logic [1:0] LANE_D = 2'd3;

  localparam int NUM_LANES = 4;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] sel);
    logic [NUM_LANES-1:0] oh;
    case (sel)
      LANE_A:  oh = 4'b0001;
      LANE_B:  oh = 4'b0010;
      LANE_C:  oh = 4'b0100;
      LANE_D:  oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/quaddemux_lane.sv
// One-deep output buffer for a single demux lane: data register plus valid flag.
// A lane is free when it is empty or is being drained this cycle.
module quaddemux_lane #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             free
);

  assign free = ~valid | ready;

  // Buffer state: a write wins over a drain, so drain+refill keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (wr) begin
      q     <= wdata;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/quaddemux.sv
// Four-lane demultiplexer: steers each accepted word to the lane picked by s,
// or to all lanes on broadcast, through a one-deep buffer per lane.
module quaddemux
  import quaddemux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       s,
  input  logic             bcast,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready
);

  logic [NUM_LANES-1:0]            ready_s;
  logic [NUM_LANES-1:0]            free_s;
  logic [NUM_LANES-1:0]            valid_s;
  logic [NUM_LANES-1:0]            target_s;
  logic [NUM_LANES-1:0]            wr_s;
  logic [NUM_LANES-1:0][WIDTH-1:0] q_s;

  assign ready_s = {d_ready, c_ready, b_ready, a_ready};

  // Target decode and acceptance; in_ready never looks at in_valid.
  always_comb begin
    target_s = 4'b0000;
    in_ready = 1'b0;
    wr_s     = 4'b0000;
    if (bcast) begin
      target_s = 4'b1111;
      in_ready = &free_s;
    end else begin
      target_s = lane_onehot(s);
      in_ready = |(free_s & target_s);
    end
    if (in_valid && in_ready) begin
      wr_s = target_s;
    end else begin
      wr_s = 4'b0000;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    quaddemux_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr_s[i]),
      .wdata (in_data),
      .ready (ready_s[i]),
      .q     (q_s[i]),
      .valid (valid_s[i]),
      .free  (free_s[i])
    );
  end

  assign a       = q_s[LANE_A];
  assign b       = q_s[LANE_B];
  assign c       = q_s[LANE_C];
  assign d       = q_s[LANE_D];
  assign a_valid = valid_s[LANE_A];
  assign b_valid = valid_s[LANE_B];
  assign c_valid = valid_s[LANE_C];
  assign d_valid = valid_s[LANE_D];

endmodule

// File: tb/tb_quaddemux.sv
// Scoreboard bench for quaddemux: accepted words are queued per lane and
// compared as each lane presents and hands off its word.
module tb_quaddemux;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   s = 2'd0;
  logic         bcast = 1'b0;
  logic [W-1:0] a, b, c, d;
  logic         a_valid, b_valid, c_valid, d_valid;
  logic [3:0]   rdy = 4'b0000;
  logic [W-1:0] qv [4];
  logic [3:0]   vv;
  logic         acc = 1'b0;

  logic [W-1:0] sb [4][$];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  quaddemux #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .s(s), .bcast(bcast),
    .a(a), .b(b), .c(c), .d(d),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(rdy[0]), .b_ready(rdy[1]), .c_ready(rdy[2]), .d_ready(rdy[3])
  );

  assign qv[0] = a;
  assign qv[1] = b;
  assign qv[2] = c;
  assign qv[3] = d;
  assign vv = {d_valid, c_valid, b_valid, a_valid};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Check lane state and in_ready away from the edge, then update the scoreboard.
  task automatic step(output logic accepted);
    logic [3:0] fr;
    logic       er;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("valid%0d", i), {31'd0, vv[i]}, {31'd0, sb[i].size() != 0});
      if (sb[i].size() != 0) chk($sformatf("data%0d", i), {24'd0, qv[i]}, {24'd0, sb[i][0]});
      fr[i] = (sb[i].size() == 0) || rdy[i];
    end
    er = bcast ? (&fr) : fr[s];
    chk("in_ready", {31'd0, in_ready}, {31'd0, er});
    for (int i = 0; i < 4; i++)
      if (sb[i].size() != 0 && rdy[i]) void'(sb[i].pop_front());
    accepted = in_valid && er;
    if (accepted)
      for (int i = 0; i < 4; i++)
        if (bcast || s == i[1:0]) sb[i].push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valids"}, {28'd0, vv}, 32'd0);
    chk({tag, "_data"}, {a, b, c, d}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // Reset, with a write attempted that must be discarded.
    #12;
    check_reset_state("rst");
    in_valid = 1'b1; s = 2'd0; in_data = 8'hFF;
    @(posedge clk); #1;
    chk("rst_write_discarded", {31'd0, a_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    step(acc); step(acc);

    // Unicast fill and stall on lane c, then independent write to lane a.
    in_valid = 1'b1; s = 2'd2; in_data = 8'h5A; rdy = 4'b0000;
    step(acc);
    in_data = 8'h77;
    step(acc);
    chk("c_held", {24'd0, c}, 32'h5A);
    s = 2'd0; in_data = 8'h11;
    step(acc);
    in_valid = 1'b0;
    step(acc);
    chk("a_written", {24'd0, a}, 32'h11);

    // Drain and refill lane c in one cycle.
    rdy = 4'b0100; in_valid = 1'b1; s = 2'd2; in_data = 8'hA5;
    step(acc);
    in_valid = 1'b0; rdy = 4'b0000;
    step(acc);
    chk("c_refill", {24'd0, c}, 32'hA5);
    chk("c_refill_valid", {31'd0, c_valid}, 32'd1);

    // Back-to-back words to lane b.
    rdy = 4'b1111; in_valid = 1'b1; s = 2'd1;
    for (int k = 1; k <= 3; k++) begin
      in_data = k[W-1:0];
      step(acc);
    end
    in_valid = 1'b0;
    step(acc); step(acc);

    // Broadcast into empty lanes, then blocked by a full lane d.
    rdy = 4'b0000; bcast = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
    step(acc);
    in_valid = 1'b0;
    step(acc);
    chk("bcast_all", {a, b, c, d}, 32'h3C3C3C3C);
    rdy = 4'b0111; in_valid = 1'b1; in_data = 8'h99;
    step(acc); step(acc);
    chk("bcast_blocked_d", {24'd0, d}, 32'h3C);
    in_valid = 1'b0; bcast = 1'b0; rdy = 4'b0000;

    // Asynchronous reset mid-operation with lanes a and d full.
    in_valid = 1'b1; s = 2'd0; in_data = 8'h42;
    step(acc);
    in_valid = 1'b0;
    step(acc);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    for (int i = 0; i < 4; i++) sb[i].delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; s = 2'd3; in_data = 8'h05;
    step(acc);
    chk("post_rst_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    step(acc);

    // Random traffic; the requester holds each request until accepted.
    acc = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = W'($urandom);
        s        = 2'($urandom);
        bcast    = ($urandom_range(0, 7) == 0);
      end
      rdy = 4'($urandom);
      step(acc);
    end
    in_valid = 1'b0; bcast = 1'b0; rdy = 4'b1111;
    step(acc); step(acc);
    for (int i = 0; i < 4; i++) chk($sformatf("drained%0d", i), sb[i].size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
